// File: rtl/octave_select.sv
// octave_select: debounced up/down scale stepping and saturating per-key frequency scaling.
module octave_select #(
    parameter int NUM_SCALES      = 5,
    parameter int INIT_SCALE      = 1,
    parameter int WRAP            = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_KEYS        = 13,
    parameter int FREQ_W          = 32,
    localparam int SCALE_W        = $clog2(NUM_SCALES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic [NUM_KEYS*FREQ_W-1:0] base_freq,
    output logic [SCALE_W-1:0]         scale,
    output logic                       scale_changed,
    output logic [NUM_KEYS*FREQ_W-1:0] note_freq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EW = FREQ_W + NUM_SCALES;
    localparam logic [SCALE_W-1:0] MAX_S  = SCALE_W'(NUM_SCALES - 1);
    localparam logic [SCALE_W-1:0] INIT_S = SCALE_W'(INIT_SCALE);

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_t;

    logic [1:0]                 w_raw;
    logic [1:0]                 w_step;
    logic [SCALE_W-1:0]         w_next;
    logic [EW-1:0]              w_ext;
    logic [NUM_KEYS*FREQ_W-1:0] w_note;
    logic [SCALE_W-1:0]         r_scale;
    logic                       r_changed;
    logic [NUM_KEYS*FREQ_W-1:0] r_note;

    assign w_raw = {btn_down, btn_up};

    // Bit 0 is the up button, bit 1 the down button.
    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic [1:0]    r_sync;
        deb_t          r_st;
        logic [CW-1:0] r_cnt;
        logic          r_step;
        logic          w_s;
        assign w_s       = r_sync[1];
        assign w_step[g] = r_step;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
                r_st   <= RELEASED;
                r_cnt  <= '0;
                r_step <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_raw[g]};
                r_step <= 1'b0;
                case (r_st)
                    RELEASED: if (w_s) begin
                        r_st  <= PRESS_WAIT;
                        r_cnt <= CW'(1);
                    end
                    PRESS_WAIT: if (!w_s) begin
                        r_st  <= RELEASED;
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_st   <= PRESSED;
                        r_cnt  <= '0;
                        r_step <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    PRESSED: if (!w_s) begin
                        r_st  <= RELEASE_WAIT;
                        r_cnt <= CW'(1);
                    end
                    RELEASE_WAIT: if (w_s) begin
                        r_st  <= PRESSED;
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_st  <= RELEASED;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    default: begin
                        r_st  <= RELEASED;
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Simultaneous up and down steps cancel.
    assign w_next = (w_step == 2'b01) ? ((r_scale == MAX_S) ? ((WRAP != 0) ? '0 : r_scale) : r_scale + SCALE_W'(1)) :
                    (w_step == 2'b10) ? ((r_scale == '0) ? ((WRAP != 0) ? MAX_S : r_scale) : r_scale - SCALE_W'(1)) :
                    r_scale;

    always_comb begin
        w_note = '0;
        w_ext  = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_ext = EW'(base_freq[k*FREQ_W +: FREQ_W]) << r_scale;
            w_note[k*FREQ_W +: FREQ_W] = (|w_ext[EW-1:FREQ_W]) ? '1 : w_ext[FREQ_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scale   <= INIT_S;
            r_changed <= 1'b0;
            r_note    <= '0;
        end else begin
            r_scale   <= w_next;
            r_changed <= (w_next != r_scale);
            r_note    <= w_note;
        end
    end

    assign scale         = r_scale;
    assign scale_changed = r_changed;
    assign note_freq     = r_note;
endmodule

// File: tb/tb_octave_select.sv
// tb_octave_select: wrap and saturate instances driven together, checked against a sample-history model.
module tb_octave_select;
    localparam int D  = 4;
    localparam int NS = 5;
    localparam int IS = 1;
    localparam int NK = 13;
    localparam int FW = 32;
    localparam int VW = NK * FW;

    logic          clk = 0;
    logic          reset = 1;
    logic          btn_up = 0;
    logic          btn_down = 0;
    logic [VW-1:0] base_freq;
    logic [2:0]    sc_o [2];
    logic          chg_o [2];
    logic [VW-1:0] note_o [2];

    int n_chk = 0;
    int n_fail = 0;

    int msc [2];
    int lvl [2];
    int run [2];
    logic h1 [2];
    logic h2 [2];
    logic pend [2];

    always #5 clk = ~clk;

    octave_select #(.NUM_SCALES(NS), .INIT_SCALE(IS), .WRAP(1), .DEBOUNCE_CYCLES(D), .NUM_KEYS(NK), .FREQ_W(FW)) u_wrap (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .base_freq(base_freq),
        .scale(sc_o[0]), .scale_changed(chg_o[0]), .note_freq(note_o[0]));

    octave_select #(.NUM_SCALES(NS), .INIT_SCALE(IS), .WRAP(0), .DEBOUNCE_CYCLES(D), .NUM_KEYS(NK), .FREQ_W(FW)) u_sat (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .base_freq(base_freq),
        .scale(sc_o[1]), .scale_changed(chg_o[1]), .note_freq(note_o[1]));

    task automatic chk(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] sat(input logic [FW-1:0] b, input int s);
        logic [63:0] v;
        v = {32'b0, b} << s;
        return (v[63:32] != 0) ? '1 : v[31:0];
    endfunction

    function automatic int next_s(input int s, input logic u, input logic d, input bit wrap);
        if (u && !d) return (s == NS - 1) ? (wrap ? 0 : s) : s + 1;
        if (d && !u) return (s == 0) ? (wrap ? NS - 1 : s) : s - 1;
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [VW-1:0] en;
        logic [1:0] raw;
        int nx;
        logic s;
        #1;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                lvl[b] = 0; run[b] = 0; h1[b] = 0; h2[b] = 0; pend[b] = 0;
            end
            for (int w = 0; w < 2; w++) begin
                msc[w] = IS;
                chk($sformatf("rst_scale%0d", w), VW'(sc_o[w]), VW'(IS));
                chk($sformatf("rst_chg%0d", w), VW'(chg_o[w]), '0);
                chk($sformatf("rst_note%0d", w), note_o[w], '0);
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                en = '0;
                for (int k = 0; k < NK; k++) en[k*FW +: FW] = sat(base_freq[k*FW +: FW], msc[w]);
                nx = next_s(msc[w], pend[0], pend[1], w == 0);
                chk($sformatf("chg%0d", w), VW'(chg_o[w]), VW'(nx != msc[w]));
                msc[w] = nx;
                chk($sformatf("scale%0d", w), VW'(sc_o[w]), VW'(nx));
                chk($sformatf("note%0d", w), note_o[w], en);
            end
            // A button level is accepted after D consecutive samples that differ from it.
            raw = {btn_down, btn_up};
            for (int b = 0; b < 2; b++) begin
                s = h2[b];
                h2[b] = h1[b];
                h1[b] = raw[b];
                pend[b] = 0;
                if (int'(s) != lvl[b]) begin
                    run[b]++;
                    if (run[b] == D) begin
                        lvl[b] = int'(s);
                        run[b] = 0;
                        pend[b] = s;
                    end
                end else run[b] = 0;
            end
        end
    end

    task automatic hold(input logic u, input logic d, input int n);
        btn_up = u;
        btn_down = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic u, input logic d);
        hold(u, d, 8);
        hold(0, 0, 8);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        for (int k = 0; k < NK; k++) base_freq[k*FW +: FW] = 32'(262 + 16 * k);
        repeat (2) @(negedge clk);
        reset = 0;
        hold(0, 0, 3);
        do_reset();
        hold(0, 0, 3);
        hold(1, 0, 20);
        hold(0, 0, 10);
        hold(1, 0, 3); hold(0, 0, 1); hold(1, 0, 3); hold(0, 0, 8);
        hold(1, 0, 6); hold(0, 0, 10);
        do_reset();
        repeat (3) press(1, 0);
        press(1, 0);
        repeat (5) press(0, 1);
        press(0, 1);
        do_reset();
        hold(1, 1, 12); hold(0, 0, 8);
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
        do_reset();
        base_freq[0 +: FW] = 32'h4000_0001;
        base_freq[FW +: FW] = 32'd1;
        press(1, 0);
        hold(0, 0, 3);
        press(1, 0);
        press(1, 0);
        hold(0, 0, 3);
        do_reset();
        hold(1, 0, 3);
        reset = 1;
        @(negedge clk);
        btn_up = 0;
        reset = 0;
        hold(0, 0, 10);
        do_reset();
        hold(1, 0, 3);
        reset = 1;
        @(negedge clk);
        reset = 0;
        hold(1, 0, 10);
        hold(0, 0, 8);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < NK; k++) base_freq[k*FW +: FW] = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 24) == 0) do_reset();
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
        end
        hold(0, 0, 10);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
